// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader and instruction memory.
// Holds the loader FSM encoding and the default word/address widths.
package instruction_loader_pkg;

    // Default instruction word width and memory address width.
    localparam int NUM_OF_BITS      = 16;
    localparam int NUM_OF_REGISTERS = 5;

    // Loader session states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/instruction_loader.sv
// Streams program words from a valid/ready source into an external
// instruction memory, one registered write per accepted word.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               begin a session (sampled in IDLE only)
//   base_addr, length   first write address and word count (0..32)
//   abort               end an active session with an error
//   in_valid, in_data   source word handshake input
//   in_ready            loader can take a word this cycle
//   wr_en/addr/data     registered memory write port
//   busy, done          session active / one-cycle completion pulse
//   error               sticky fault (empty session or abort)
//   checksum            modular sum of words accepted this session
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int Num_of_bits      = NUM_OF_BITS,
    parameter int Num_of_registers = NUM_OF_REGISTERS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [Num_of_registers-1:0] base_addr,
    input  logic [Num_of_registers:0]   length,
    input  logic                        abort,
    input  logic                        in_valid,
    input  logic [Num_of_bits-1:0]      in_data,
    output logic                        in_ready,
    output logic                        wr_en,
    output logic [Num_of_registers-1:0] wr_addr,
    output logic [Num_of_bits-1:0]      wr_data,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [Num_of_bits-1:0]      checksum
);

    localparam logic [Num_of_registers:0] REM_ONE =
        (Num_of_registers+1)'(1);

    state_e state_q, state_d;

    logic [Num_of_registers-1:0] addr_q, addr_d;
    logic [Num_of_registers:0]   rem_q, rem_d;
    logic [Num_of_bits-1:0]      csum_q, csum_d;
    logic                        err_q, err_d;
    logic                        wr_en_q, wr_en_d;
    logic [Num_of_registers-1:0] wr_addr_q, wr_addr_d;
    logic [Num_of_bits-1:0]      wr_data_q, wr_data_d;

    logic accept;
    logic empty_start;

    assign empty_start = (length == '0);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = empty_start ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Abort wins over a word offered in the same cycle.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept && (rem_q == REM_ONE)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs decoded from the current state
    // ---------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                in_ready = ~abort;
                busy     = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign accept = in_valid & in_ready;

    // ---------------------------------------------------------------
    // Datapath next-state
    // ---------------------------------------------------------------
    always_comb begin
        addr_d    = addr_q;
        rem_d     = rem_q;
        csum_d    = csum_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // An empty session still starts a fresh checksum.
                    csum_d = '0;
                    if (empty_start) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = base_addr;
                        rem_d  = length;
                        err_d  = 1'b0;
                    end
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    err_d = 1'b1;
                end else if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = in_data;
                    // Address wraps naturally at the memory depth.
                    addr_d    = addr_q + 1'b1;
                    rem_d     = rem_q - 1'b1;
                    csum_d    = csum_q + in_data;
                end
            end
            default: begin
                wr_en_d = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            rem_q     <= '0;
            csum_q    <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            csum_q    <= csum_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign error    = err_q;
    assign checksum = csum_q;

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter Num_of_bits, default 16: instruction word width.
REQ-002 Parameter Num_of_registers, default 5: memory address width (depth 2**Num_of_registers = 32 words).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a load session; sampled only in IDLE.
REQ-006 base_addr  input  Num_of_registers  first memory address to write; latched on accepted start.
REQ-007 length  input  Num_of_registers+1  words to load, 0..32; latched on accepted start.
REQ-008 abort  input  1  terminate an active session.
REQ-009 in_valid  input  1  source holds a valid word on in_data.
REQ-010 in_data  input  Num_of_bits  program word (instruction or immediate).
REQ-011 in_ready  output  1  loader accepts a word this cycle.
REQ-012 wr_en  output  1  memory write strobe, one cycle per word.
REQ-013 wr_addr  output  Num_of_registers  memory write address.
REQ-014 wr_data  output  Num_of_bits  memory write data.
REQ-015 busy  output  1  high in LOAD.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 error  output  1  sticky fault flag.
REQ-018 checksum  output  Num_of_bits  mod-2**Num_of_bits sum of words accepted this session.

Function
REQ-019 FSM states: IDLE, LOAD, DONE.
REQ-020 IDLE: start=1 and length!=0 -> LOAD; latch base_addr into address counter and length into remaining counter; clear checksum and error.
REQ-021 IDLE: start=1 and length=0 -> DONE; set error; perform no writes.
REQ-022 in_ready = (state==LOAD) and not abort, combinational; low in IDLE and DONE.
REQ-023 Handshake: word accepted at a rising edge where in_valid=1 and in_ready=1; in_data is not consumed otherwise; in_valid may toggle freely.
REQ-024 On acceptance: registered wr_en=1, wr_addr=current address, wr_data=in_data during the following cycle; wr_en=0 in all other cycles.
REQ-025 Address counter increments by 1 per accepted word, wrapping 31 -> 0 modulo 2**Num_of_registers; wrap is not an error.
REQ-026 Remaining counter decrements per accepted word; acceptance of the final word moves LOAD -> DONE.
REQ-027 checksum updates on each accepted word, wrapping modulo 2**Num_of_bits; it holds after the session until the next accepted start.
REQ-028 DONE lasts exactly one cycle, asserts done=1, then returns to IDLE; the final wr_en occurs in the same cycle as done.
REQ-029 abort=1 in LOAD: no word accepted that cycle; next state IDLE; error set; done not asserted.
REQ-030 abort in IDLE or DONE has no effect; start in LOAD or DONE is ignored.
REQ-031 Back-to-back: start sampled in the IDLE cycle directly following DONE is accepted.

Reset
REQ-032 rst_n=0 forces immediately: state IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, checksum=0, counters=0.
REQ-033 Reset during LOAD discards the session; no further writes after rst_n falls; operation resumes at first edge after rst_n rises.

Structure
REQ-034 Shared package holds the FSM state encoding and default Num_of_bits/Num_of_registers constants shared with instruction_memory.
REQ-035 Single module; no sub-module required; memory array is external, driven via wr_en/wr_addr/wr_data.

Verification
REQ-036 base_addr=0, length=3, words 0x1111,0x2222,0x3333 with in_valid held high -> writes to addr 0,1,2 on consecutive cycles; done with final write; checksum=0x6666.
REQ-037 base_addr=30, length=4 -> writes to addr 30,31,0,1; error=0.
REQ-038 length=0 start -> no wr_en; done pulse one cycle later; error=1.
REQ-039 length=2, in_valid gaps of 3 cycles between words -> exactly 2 writes, each one cycle after its handshake; busy high throughout.
REQ-040 length=4, abort after 2 words, simultaneous with in_valid=1 -> in_ready=0 that cycle; exactly 2 writes; error=1; no done.
REQ-041 rst_n pulsed low mid-LOAD -> all outputs zero immediately; later start with length=1 completes normally with error=0.
